// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
//   Iterative RV32M multiply/divide unit for the execute stage. One operation is
//   accepted through a valid/ready handshake, computed one bit per cycle
//   (radix-2 shift-add multiply or restoring divide), sign-corrected in a single
//   ADJUST cycle and then held in DONE until the consumer takes it.
//   Divide-by-zero and signed DIV/REM overflow bypass the iteration and go
//   straight to DONE. A synchronous flush aborts whatever is in flight.
//
// Ports
//   clk, rst_n      clock (rising edge), asynchronous active-low reset
//   in_valid/ready  request handshake; in_ready is high only in IDLE
//   op, a, b        operation code and rs1/rs2 operands
//   flush           synchronous abort, wins over any handshake
//   out_valid/ready result handshake; out_valid is high only in DONE
//   result          registered result, stable while out_valid is high
//   busy            unit is not IDLE
// -----------------------------------------------------------------------------
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_ADJUST,
    S_DONE
  } state_e;

  state_e             state_q;
  op_e                op_q;
  logic [CW-1:0]      cnt_q;
  logic [WIDTH-1:0]   opnd_q;      // |b|: multiplicand or divisor
  logic [2*WIDTH-1:0] prod_q;      // mul: {acc, multiplier}; div: {rem, quotient}
  logic               neg_q;       // product / quotient must be negated
  logic               rem_neg_q;   // remainder takes the dividend's sign
  logic [WIDTH-1:0]   result_q;

  // ---------------------------------------------------------------------------
  // Operand conditioning at accept time
  // ---------------------------------------------------------------------------
  logic             a_signed, b_signed, a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic             div_zero, div_ovf, fast_path;
  logic [WIDTH-1:0] fast_result;
  logic [CW-1:0]    cnt_d;

  always_comb begin
    // NOTE: every signal assigned in a combinational block gets a default
    // first, so no path can leave it unassigned and infer a latch.
    a_signed    = 1'b0;
    b_signed    = 1'b0;
    fast_result = '0;
    unique case (op_e'(op))
      OP_MULH:        begin a_signed = 1'b1; b_signed = 1'b1; end
      OP_MULHSU:      a_signed = 1'b1;
      OP_DIV, OP_REM: begin a_signed = 1'b1; b_signed = 1'b1; end
      default:        ;
    endcase

    a_neg = a_signed & a[WIDTH-1];
    b_neg = b_signed & b[WIDTH-1];
    // Negating the most-negative value yields itself, which read unsigned is
    // exactly its magnitude.
    a_mag = a_neg ? -a : a;
    b_mag = b_neg ? -b : b;

    // op[2] selects the divide group, op[0]=0 the signed variants, op[1] REM.
    div_zero  = op[2] & (b == '0);
    div_ovf   = op[2] & ~op[0] & (a == MOST_NEG) & (&b);
    fast_path = div_zero | div_ovf;
    if (div_zero)
      fast_result = op[1] ? a : '1;
    else if (div_ovf)
      fast_result = op[1] ? '0 : a;

    cnt_d = cnt_q - CW'(1);
  end

  // ---------------------------------------------------------------------------
  // One iteration step (multiply or restoring divide)
  // ---------------------------------------------------------------------------
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift, div_diff;
  logic [2*WIDTH-1:0] prod_d;

  always_comb begin
    // Shift-add: add the multiplicand into the high half when the current
    // multiplier LSB is set, then shift the whole register right by one.
    mul_sum = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, opnd_q} : '0);

    // Restoring divide: bring the next dividend bit into the partial
    // remainder and try to subtract the divisor; bit WIDTH of the difference
    // is set exactly when the trial subtraction went negative.
    div_shift = {prod_q[2*WIDTH-1:WIDTH], prod_q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opnd_q};

    if (op_q[2]) begin
      if (!div_diff[WIDTH])
        prod_d = {div_diff[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b1};
      else
        prod_d = {div_shift[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b0};
    end else begin
      prod_d = {mul_sum, prod_q[WIDTH-1:1]};
    end
  end

  // ---------------------------------------------------------------------------
  // Sign correction and result selection (ADJUST)
  // ---------------------------------------------------------------------------
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix, rem_fix, adj_result;

  always_comb begin
    prod_fix = neg_q ? -prod_q : prod_q;
    quot_fix = neg_q ? -prod_q[WIDTH-1:0] : prod_q[WIDTH-1:0];
    rem_fix  = rem_neg_q ? -prod_q[2*WIDTH-1:WIDTH] : prod_q[2*WIDTH-1:WIDTH];
    unique case (op_q)
      OP_MUL:                       adj_result = prod_fix[WIDTH-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: adj_result = prod_fix[2*WIDTH-1:WIDTH];
      OP_DIV, OP_DIVU:              adj_result = quot_fix;
      default:                      adj_result = rem_fix;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM and datapath registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the datapath registers are reset too; they are few and plain
      // flops, so a defined value after reset costs nothing.
      state_q   <= S_IDLE;
      op_q      <= OP_MUL;
      cnt_q     <= '0;
      opnd_q    <= '0;
      prod_q    <= '0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      result_q  <= '0;
    end else if (flush) begin
      // Flush beats both handshakes: nothing is accepted, any result dropped.
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            op_q <= op_e'(op);
            if (fast_path) begin
              result_q <= fast_result;
              state_q  <= S_DONE;
            end else begin
              opnd_q    <= b_mag;
              prod_q    <= {{WIDTH{1'b0}}, a_mag};
              neg_q     <= a_neg ^ b_neg;
              rem_neg_q <= a_neg;
              cnt_q     <= CW'(WIDTH);
              state_q   <= S_CALC;
            end
          end
        end
        S_CALC: begin
          prod_q <= prod_d;
          cnt_q  <= cnt_d;
          if (cnt_d == '0)
            state_q <= S_ADJUST;
        end
        S_ADJUST: begin
          result_q <= adj_result;
          state_q  <= S_DONE;
        end
        S_DONE: begin
          if (out_ready)
            state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Handshake outputs are decoded from the state register alone.
  assign in_ready  = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign result    = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// -----------------------------------------------------------------------------
// tb_muldiv_unit
//   Self-checking bench for muldiv_unit (WIDTH = 32). Expected results are
//   pushed to a scoreboard queue at accept and compared when the unit hands a
//   result over. Directed vectors use hand-derived constants; random vectors
//   use an independent RV32M reference model built on 64-bit arithmetic.
// -----------------------------------------------------------------------------
module tb_muldiv_unit;

  localparam int W = 32;
  localparam logic [2:0] MUL = 3'd0, MULH = 3'd1, MULHSU = 3'd2, MULHU = 3'd3;
  localparam logic [2:0] DIV = 3'd4, DIVU = 3'd5, REM = 3'd6, REMU = 3'd7;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid, in_ready;
  logic [2:0]   op;
  logic [W-1:0] a, b;
  logic         flush;
  logic         out_valid, out_ready;
  logic [W-1:0] result;
  logic         busy;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  logic [W-1:0] sb[$];

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Independent reference for RV32M semantics.
  function automatic logic [W-1:0] model(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    longint          sx = longint'($signed(x));
    longint          sy = longint'($signed(y));
    longint unsigned ux = longint'(x);
    longint unsigned uy = longint'(y);
    longint unsigned p;
    logic            ovf = (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
    case (o)
      MUL:    begin p = ux * uy;                  return p[31:0];  end
      MULH:   begin p = longint'(sx * sy);        return p[63:32]; end
      MULHSU: begin p = longint'(sx * longint'(uy)); return p[63:32]; end
      MULHU:  begin p = ux * uy;                  return p[63:32]; end
      DIV:    begin
        if (y == 0) return '1;
        if (ovf)    return x;
        p = longint'(sx / sy); return p[31:0];
      end
      DIVU:   begin if (y == 0) return '1; p = ux / uy; return p[31:0]; end
      REM:    begin
        if (y == 0) return x;
        if (ovf)    return '0;
        p = longint'(sx % sy); return p[31:0];
      end
      default: begin if (y == 0) return x; p = ux % uy; return p[31:0]; end
    endcase
  endfunction

  // Result monitor: pops the scoreboard on every completed output handshake.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() > 0) check("result", result, sb.pop_front());
      else               check("spurious_out", {31'b0, out_valid}, '0);
    end
  end

  // Entered and left at posedge+1. Drives one request and returns just after
  // the accept edge with the operands already scrambled.
  task automatic send(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                      input logic [W-1:0] e, input bit push);
    int k = 0;
    while (!in_ready && k < 100) begin
      @(posedge clk); #1; k++;
    end
    check("in_ready_wait", {31'b0, in_ready}, 32'd1);
    in_valid = 1'b1; op = o; a = x; b = y;
    @(posedge clk);
    if (push) sb.push_back(e);
    #1;
    in_valid = 1'b0;
    op = 3'($urandom); a = $urandom; b = $urandom;
  endtask

  // Counts edges from accept to the first edge that sees out_valid high.
  task automatic wait_valid(input string tag, input int exp_lat);
    int lat = -1;
    bit busy_ok = 1'b1;
    for (int j = 0; j < 100; j++) begin
      @(negedge clk);
      if (!busy) busy_ok = 1'b0;
      if (out_valid) begin
        lat = j + 1;
        break;
      end
    end
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    check({tag, "_busy"}, {31'b0, busy_ok}, 32'd1);
  endtask

  // With out_ready high the result goes at the next edge; in_ready follows.
  task automatic drain(input string tag);
    @(posedge clk); #1;
    check({tag, "_in_ready_after"}, {31'b0, in_ready}, 32'd1);
  endtask

  task automatic run(input string tag, input logic [2:0] o, input logic [W-1:0] x,
                     input logic [W-1:0] y, input logic [W-1:0] e, input int lat);
    send(o, x, y, e, 1'b1);
    wait_valid(tag, lat);
    drain(tag);
  endtask

  task automatic quiet(input string tag, input int n);
    int c = 0;
    repeat (n) begin
      @(negedge clk);
      if (out_valid) c++;
    end
    check(tag, 32'(c), '0);
    @(posedge clk); #1;
  endtask

  initial begin
    #200_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit bp_ok;
    rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    op = '0; a = '0; b = '0;
    #3;
    check("rst_in_ready",  {31'b0, in_ready},  32'd1);
    check("rst_busy",      {31'b0, busy},      '0);
    check("rst_out_valid", {31'b0, out_valid}, '0);
    check("rst_result",    result,             '0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed vectors (normal latency 34, fast path 1).
    run("mul",       MUL,    32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 34);
    run("mulh",      MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34);
    run("mulhu",     MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34);
    run("mulhsu",    MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34);
    run("div_neg",   DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 34);
    run("rem_neg",   REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 34);
    run("divu",      DIVU,   32'd100,       32'd7,         32'd14,        34);
    run("remu",      REMU,   32'd100,       32'd7,         32'd2,         34);
    run("rem_negb",  REM,    32'd7,         32'hFFFF_FFFE, 32'd1,         34);
    run("div_by0",   DIV,    32'd5,         32'd0,         32'hFFFF_FFFF, 1);
    run("remu_by0",  REMU,   32'd5,         32'd0,         32'd5,         1);
    run("divu_by0",  DIVU,   32'd9,         32'd0,         32'hFFFF_FFFF, 1);
    run("rem_by0",   REM,    32'hFFFF_FFF0, 32'd0,         32'hFFFF_FFF0, 1);
    run("div_ovf",   DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    run("rem_ovf",   REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1);

    // Random vectors against the reference model.
    for (int i = 0; i < 12; i++) begin
      logic [2:0]   ro = 3'($urandom_range(0, 7));
      logic [W-1:0] ra = $urandom;
      logic [W-1:0] rb = (i % 4 == 3) ? '0 : ((i % 3 == 0) ? 32'($urandom_range(1, 300)) : $urandom);
      int           rl = (ro[2] && rb == '0) ? 1 : 34;
      run("rand", ro, ra, rb, model(ro, ra, rb), rl);
    end

    // Backpressure: result held for 10 cycles, new requests ignored.
    out_ready = 1'b0;
    send(MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b1);
    wait_valid("bp", 34);
    bp_ok = 1'b1;
    repeat (10) begin
      @(posedge clk); #1;
      in_valid = 1'b1; op = DIVU; a = 32'd9; b = 32'd3;
      @(negedge clk);
      if (!out_valid || result !== 32'hFFFF_FFFE || in_ready || !busy) bp_ok = 1'b0;
    end
    in_valid = 1'b0;
    check("bp_stable", {31'b0, bp_ok}, 32'd1);
    @(posedge clk); #1;
    out_ready = 1'b1;
    drain("bp_release");
    run("bp_next", DIVU, 32'd100, 32'd7, 32'd14, 34);

    // Flush on the 10th CALC cycle.
    send(MUL, 32'd123, 32'd456, '0, 1'b0);
    repeat (9) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_in_ready", {31'b0, in_ready}, 32'd1);
    check("flush_busy",     {31'b0, busy},     '0);
    quiet("flush_no_valid", 40);

    // Flush together with in_valid in IDLE: nothing accepted.
    in_valid = 1'b1; flush = 1'b1; op = DIV; a = 32'd5; b = 32'd0;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    check("flush_idle_busy", {31'b0, busy}, '0);
    quiet("flush_idle_no_valid", 10);

    // Reset mid-CALC; also hold in_valid during reset.
    send(MULHU, 32'hDEAD_BEEF, 32'h1234_5678, '0, 1'b0);
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0; in_valid = 1'b1; op = DIV; a = 32'd1; b = 32'd0;
    #1;
    check("rstmid_busy",      {31'b0, busy},      '0);
    check("rstmid_out_valid", {31'b0, out_valid}, '0);
    check("rstmid_result",    result,             '0);
    check("rstmid_in_ready",  {31'b0, in_ready},  32'd1);
    repeat (2) @(posedge clk);
    #1 in_valid = 1'b0;
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rstmid_idle_after", {31'b0, busy}, '0);
    quiet("rstmid_no_valid", 40);
    run("post_reset", REMU, 32'd1000, 32'd33, 32'd10, 34);

    check("sb_drained", 32'(sb.size()), '0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative RV32M multiply/divide unit, parametrised in operand width, sitting in the execute stage beside the single-cycle ALU. It accepts one operation through a valid/ready input handshake and computes it over multiple cycles using a radix-2 shift-add multiply or a restoring divide. The result is held behind an output valid/ready handshake, so the pipeline can stall on it. Divide-by-zero and signed overflow complete on a one-cycle fast path, and a synchronous flush aborts any in-flight operation.

## Interface
- WIDTH, 32: operand and result width (≥ 4).
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operation request.
- in_ready  output  1  unit can accept; high only in IDLE.
- op  input  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- a  input  WIDTH  rs1 operand.
- b  input  WIDTH  rs2 operand.
- flush  input  1  synchronous abort of the current operation.
- out_valid  output  1  result available.
- out_ready  input  1  consumer takes result.
- result  output  WIDTH  operation result.
- busy  output  1  state ≠ IDLE.

## Operation
- **States:** IDLE, CALC, ADJUST, DONE.
- **Accept:** `in_valid & in_ready` at a rising edge. On accept, op, a, b are latched; inputs may change afterwards.
- **IDLE → CALC** on a normal accept. The counter is loaded with WIDTH, and operands are converted to magnitudes according to op signedness:
  - MULHSU: a signed, b unsigned.
  - DIV, REM: both signed.
  - MUL: sign irrelevant (low half).
- **IDLE → DONE** directly (fast path) on accept when op is DIV/DIVU/REM/REMU with b = 0, or DIV/REM with a = most-negative and b = all-ones.
- **CALC:** one bit per cycle. Multiply accumulates into a 2·WIDTH product register; divide shifts in one quotient bit. The counter decrements each cycle, and at 0 the unit moves to ADJUST.
- **ADJUST:** one cycle.
  - Negate the product if operand signs differ.
  - Negate the quotient if operand signs differ.
  - Remainder takes the dividend's sign.
  - Select the result: MUL takes the low WIDTH bits; MULH/MULHSU/MULHU take the high WIDTH bits. Then go to DONE.
- **DONE:** out_valid = 1 and result is stable. When out_ready = 1 at an edge, go to IDLE. No new accept is possible in DONE.
- **Special results:**
  - Divide by zero: quotient = all-ones; remainder = a.
  - Overflow (DIV/REM): quotient = a (most-negative); remainder = 0.
- **flush:** from any state, the next edge goes to IDLE, out_valid drops, and the result is discarded. If flush and in_valid occur in the same IDLE cycle, flush wins and nothing is accepted. In DONE, flush wins over out_ready (the result is dropped).
- **Reset:** asynchronous. state = IDLE, result = 0, out_valid = 0, busy = 0, counter = 0, and all internal registers = 0. in_ready is high in IDLE, including while rst_n is low; no accept occurs while reset is asserted.

## Timing
- in_ready, busy, and out_valid are decoded from the state register only (no combinational input-to-output paths).
- **Normal latency:** accept at edge T, then WIDTH CALC cycles and 1 ADJUST cycle. out_valid is high from edge T+WIDTH+2 (34 cycles for WIDTH = 32).
- **Fast path:** out_valid is high from edge T+1.
- **Throughput:** if out_ready is held high, a result is consumed at the first DONE edge. in_ready rises the cycle after, so back-to-back ops cost latency + 2 cycles each.
- **Backpressure:** result and out_valid stay unchanged for as long as out_ready = 0.
- **Reset mid-operation:** the operation is lost immediately. No out_valid is produced after rst_n rises.

## Test plan
- **Multiply:** MUL a = 7, b = 0xFFFFFFFD → result 0xFFFFFFEB. out_valid first seen exactly 34 cycles after the accept edge, and busy is high throughout.
- **High-half multiplies:**
  - MULH 0x80000000 × 0x80000000 → 0x40000000.
  - MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE.
  - MULHSU a = 0xFFFFFFFF, b = 0xFFFFFFFF → 0xFFFFFFFF.
- **Divide/remainder:**
  - DIV −7/2 → 0xFFFFFFFD; REM −7/2 → 0xFFFFFFFF.
  - DIVU 100/7 → 14; REMU 100/7 → 2.
  - REM 7/−2 → 1.
- **Fast path:**
  - DIV 5/0 → 0xFFFFFFFF; REMU 5/0 → 5.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM of the same → 0.
  - Each with out_valid at accept + 1.
- **Backpressure and inputs:**
  - Hold out_ready = 0 for 10 cycles in DONE → result and out_valid stable, in_ready = 0, in_valid ignored.
  - Release out_ready → in_ready = 1 the next cycle and the next op is accepted.
  - Change a/b after accept → result unaffected.
- **Flush and reset:**
  - Flush on the 10th CALC cycle → out_valid never asserts and in_ready = 1 the next cycle.
  - Flush together with in_valid in IDLE → no accept.
  - Drop rst_n mid-CALC → outputs zero immediately and state is IDLE after release.
